// File: rtl/cayde_alu_seq_if.sv
// Request/result handshake bundle for cayde_alu_seq; master = requester, slave = ALU.
// One request in flight at a time; the result is held until the requester takes it.
interface cayde_alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [6:0]      op_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] res_o;
  logic            busy_o;

  modport master (
    output in_valid_i, op_i, op_a_i, op_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, busy_o
  );

  modport slave (
    input  in_valid_i, op_i, op_a_i, op_b_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, busy_o
  );
endinterface

// File: rtl/cayde_alu_seq.sv
// Sequential ALU: 1-cycle ops, XLEN-cycle shift-add MUL and restoring DIVU/REMU.
// Latency 1 or XLEN+1 edges; result held in DONE until out_ready_i, requests refused unless IDLE.
module cayde_alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic clk_i,
  input  logic rst_ni,
  cayde_alu_seq_if.slave bus
);

  localparam logic [6:0] OP_ADD  = 7'd0;
  localparam logic [6:0] OP_SUB  = 7'd1;
  localparam logic [6:0] OP_XOR  = 7'd2;
  localparam logic [6:0] OP_AND  = 7'd3;
  localparam logic [6:0] OP_OR   = 7'd4;
  localparam logic [6:0] OP_SLL  = 7'd5;
  localparam logic [6:0] OP_SLT  = 7'd6;
  localparam logic [6:0] OP_SLTU = 7'd7;
  localparam logic [6:0] OP_SRL  = 7'd8;
  localparam logic [6:0] OP_SRA  = 7'd9;
  localparam logic [6:0] OP_MUL  = 7'd10;
  localparam logic [6:0] OP_DIVU = 7'd11;
  localparam logic [6:0] OP_REMU = 7'd12;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nx;
  logic [6:0]      op_q;
  logic [XLEN-1:0] a_q;   // MUL: shifting multiplicand; DIV: dividend shifting into quotient
  logic [XLEN-1:0] b_q;   // MUL: shifting multiplier;   DIV: divisor
  logic [XLEN-1:0] acc_q; // MUL: partial product;       DIV: partial remainder
  logic [XLEN-1:0] res_q;
  logic [SHW-1:0]  cnt_q;

  logic            accept;
  logic            is_multi;
  logic            last_iter;
  logic [XLEN-1:0] single_res;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] mul_acc_nx;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_diff;
  logic            rem_ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;

  assign accept    = (state == IDLE) && bus.in_valid_i;
  assign is_multi  = (bus.op_i == OP_MUL) || (bus.op_i == OP_DIVU) || (bus.op_i == OP_REMU);
  assign last_iter = (cnt_q == SHW'(XLEN - 1));
  assign shamt     = bus.op_b_i[SHW-1:0];

  always_comb begin
    single_res = '0;
    unique case (bus.op_i)
      OP_ADD:  single_res = bus.op_a_i + bus.op_b_i;
      OP_SUB:  single_res = bus.op_a_i - bus.op_b_i;
      OP_XOR:  single_res = bus.op_a_i ^ bus.op_b_i;
      OP_AND:  single_res = bus.op_a_i & bus.op_b_i;
      OP_OR:   single_res = bus.op_a_i | bus.op_b_i;
      OP_SLL:  single_res = bus.op_a_i << shamt;
      OP_SLT:  single_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a_i) < $signed(bus.op_b_i))};
      OP_SLTU: single_res = {{(XLEN-1){1'b0}}, (bus.op_a_i < bus.op_b_i)};
      OP_SRL:  single_res = bus.op_a_i >> shamt;
      OP_SRA:  single_res = $unsigned($signed(bus.op_a_i) >>> shamt);
      default: single_res = '0;
    endcase
  end

  // One iteration of each long op; a zero divisor naturally yields all-ones / dividend.
  always_comb begin
    mul_acc_nx = acc_q + (b_q[0] ? a_q : '0);
    rem_sh     = {acc_q, a_q[XLEN-1]};
    rem_diff   = rem_sh - {1'b0, b_q};
    rem_ge     = ~rem_diff[XLEN];
    rem_nx     = rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx     = {a_q[XLEN-2:0], rem_ge};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = is_multi ? EXEC : DONE;
      EXEC:    if (last_iter) state_nx = DONE;
      DONE:    if (bus.out_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready_o  = (state == IDLE);
    bus.out_valid_o = (state == DONE);
    bus.busy_o      = (state != IDLE);
    bus.res_o       = res_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= bus.op_i;
            a_q   <= bus.op_a_i;
            b_q   <= bus.op_b_i;
            acc_q <= '0;
            cnt_q <= '0;
            if (!is_multi) res_q <= single_res;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q == OP_MUL) begin
            acc_q <= mul_acc_nx;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= rem_nx;
            a_q   <= quo_nx;
          end
          if (last_iter) begin
            if (op_q == OP_MUL)       res_q <= mul_acc_nx;
            else if (op_q == OP_DIVU) res_q <= quo_nx;
            else                      res_q <= rem_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cayde_alu_seq.sv
// Directed + random bench for cayde_alu_seq against a plain-arithmetic reference model.
module tb_cayde_alu_seq;
  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  cayde_alu_seq_if #(.XLEN(XLEN)) bus ();

  cayde_alu_seq #(.XLEN(XLEN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      7'd0:  r = a + b;
      7'd1:  r = a - b;
      7'd2:  r = a ^ b;
      7'd3:  r = a & b;
      7'd4:  r = a | b;
      7'd5:  r = a << b[4:0];
      7'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7'd7:  r = (a < b) ? 32'd1 : 32'd0;
      7'd8:  r = a >> b[4:0];
      7'd9:  r = $unsigned($signed(a) >>> b[4:0]);
      7'd10: r = a * b;
      7'd11: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      7'd12: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency from the accepting edge, optionally stall the result.
  task automatic run_op(input string tag, input logic [6:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall, input bit noise);
    int          edges;
    int          w;
    bit          busy_ok;
    bit          stable;
    logic [31:0] held;
    logic [31:0] exp;
    exp = model(op, a, b);
    w = 0;
    while (!bus.in_ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, {31'd0, bus.in_ready_o}, 32'd1);
    @(negedge clk);
    bus.in_valid_i  = 1'b1;
    bus.op_i        = op;
    bus.op_a_i      = a;
    bus.op_b_i      = b;
    bus.out_ready_i = (stall == 0);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.op_i       = 7'($urandom);
    bus.op_a_i     = $urandom;
    bus.op_b_i     = $urandom;
    edges   = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid_o && edges < 200) begin
      if (!bus.busy_o) busy_ok = 1'b0;
      if (noise) bus.in_valid_i = 1'($urandom);
      @(posedge clk);
      #1;
      edges++;
    end
    bus.in_valid_i = 1'b0;
    check({tag, "_valid"}, {31'd0, bus.out_valid_o}, 32'd1);
    check({tag, "_lat"}, edges, (op == 7'd10 || op == 7'd11 || op == 7'd12) ? 32'd33 : 32'd1);
    check({tag, "_res"}, bus.res_o, exp);
    check({tag, "_busy"}, {31'd0, busy_ok & bus.busy_o}, 32'd1);
    if (stall > 0) begin
      held   = bus.res_o;
      stable = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        #1;
        if (!bus.out_valid_o || bus.res_o !== held) stable = 1'b0;
      end
      check({tag, "_hold"}, {31'd0, stable}, 32'd1);
      bus.out_ready_i = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_handoff"}, {30'd0, bus.out_valid_o, bus.in_ready_o}, 32'd1);
  endtask

  initial begin
    logic [6:0]  rop;
    logic [31:0] ra, rb;
    rst_n           = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.op_i        = '0;
    bus.op_a_i      = '0;
    bus.op_b_i      = '0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {bus.out_valid_o, bus.busy_o, 30'd0}, 32'd0);
    check("rst_res", bus.res_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.in_ready_o}, 32'd1);

    run_op("add_wrap", 7'd0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op("sra", 7'd9, 32'h8000_0000, 32'h0000_0024, 0, 1'b0);
    run_op("slt", 7'd6, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op("sltu", 7'd7, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op("mul", 7'd10, 32'h0001_0001, 32'h0001_0001, 0, 1'b1);
    run_op("divu", 7'd11, 32'd100, 32'd7, 0, 1'b1);
    run_op("remu", 7'd12, 32'd100, 32'd7, 0, 1'b0);
    run_op("divu0", 7'd11, 32'h1234_5678, 32'd0, 0, 1'b0);
    run_op("remu0", 7'd12, 32'd5, 32'd0, 0, 1'b0);
    run_op("badop", 7'd77, 32'hDEAD_BEEF, 32'd3, 0, 1'b0);
    run_op("stall_sub", 7'd1, 32'd3, 32'd10, 5, 1'b0);
    run_op("stall_mul", 7'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0);

    // Abort a DIVU partway through its iterations.
    @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.op_i       = 7'd11;
    bus.op_a_i     = 32'd1000;
    bus.op_b_i     = 32'd3;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outs", {bus.out_valid_o, bus.busy_o, 30'd0}, 32'd0);
    check("abort_res", bus.res_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", {31'd0, bus.in_ready_o}, 32'd1);
    check("abort_novalid", {31'd0, bus.out_valid_o}, 32'd0);
    run_op("post_add", 7'd0, 32'd2, 32'd3, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rop = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 12));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      run_op("rand", rop, ra, rb, $urandom_range(0, 3) == 0 ? 3 : 0, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cayde_alu_seq.md
CAYDE_ALU_SEQ -- requirements
Module: cayde_alu_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, setting the operand/result width; legal values are powers of two, 8 to 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(XLEN), setting the shift-amount width taken from op_b_i[SHW-1:0].
REQ-003 The block SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid_i, input, 1: request valid.
REQ-006 The block SHALL have port in_ready_o, output, 1: block can accept a request.
REQ-007 The block SHALL have port op_i, input, 7: operation code.
REQ-008 The block SHALL have ports op_a_i and op_b_i, input, XLEN each: operands.
REQ-009 The block SHALL have port out_valid_o, output, 1: result valid.
REQ-010 The block SHALL have port out_ready_i, input, 1: consumer accepts result.
REQ-011 The block SHALL have port res_o, output, XLEN: result.
REQ-012 The block SHALL have port busy_o, output, 1: high whenever state is not IDLE.

Function
REQ-013 Opcodes SHALL be: 0 ADD, 1 SUB, 2 XOR, 3 AND (bitwise), 4 OR (bitwise), 5 SLL, 6 SLT (signed, result 0/1), 7 SLTU (result 0/1), 8 SRL, 9 SRA, 10 MUL (low XLEN bits), 11 DIVU, 12 REMU.
REQ-014 Any other opcode SHALL be executed as a single-cycle op with result 0.
REQ-015 ADD/SUB/MUL SHALL wrap modulo 2^XLEN; no carry/overflow is reported.
REQ-016 Shift ops SHALL use only op_b_i[SHW-1:0]; SRA SHALL replicate op_a_i[XLEN-1].
REQ-017 The FSM SHALL have states IDLE, EXEC, DONE.
REQ-018 in_ready_o SHALL be high only in IDLE; a request is accepted on an edge where in_valid_i and in_ready_o are both high.
REQ-019 Operands and opcode SHALL be registered on acceptance; later input changes SHALL NOT affect the result.
REQ-020 Single-cycle ops (0-9 and unlisted opcodes) SHALL go IDLE->DONE at acceptance, so out_valid_o is high on the first edge after acceptance (latency 1).
REQ-021 MUL/DIVU/REMU SHALL go IDLE->EXEC and iterate one bit per cycle (shift-add multiply, restoring divide) for exactly XLEN cycles, then enter DONE; out_valid_o rises XLEN+1 edges after acceptance.
REQ-022 DIVU with op_b = 0 SHALL return all ones; REMU with op_b = 0 SHALL return op_a; both SHALL still take the full XLEN+1 latency.
REQ-023 In DONE, out_valid_o SHALL be high and res_o stable until the edge where out_ready_i is high, then the FSM SHALL return to IDLE.
REQ-024 The block SHALL NOT accept a new request in the same cycle as result handoff; minimum request spacing is 2 cycles.
REQ-025 res_o SHALL hold its last value outside DONE; it is don't-care when out_valid_o is low.
REQ-026 in_valid_i SHALL be ignored in EXEC and DONE; there is no cancel/flush.

Reset
REQ-027 While rst_ni is low: state SHALL be IDLE, out_valid_o 0, res_o 0, busy_o 0, and internal iteration counter/accumulators 0.
REQ-028 in_ready_o SHALL be 1 from the first edge after rst_ni deasserts.
REQ-029 Reset asserted mid-EXEC or in DONE SHALL abort the operation with no result produced.

Verification
REQ-030 ADD 0xFFFFFFFF + 1, out_ready_i=1 -> out_valid_o at edge+1, res_o = 0x00000000, in_ready_o back high at edge+2.
REQ-031 SRA 0x80000000 by op_b 0x00000024 (shamt 4) -> res_o = 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
REQ-032 MUL 0x00010001 * 0x00010001 -> res_o = 0x00020001 exactly 33 edges after acceptance; busy_o high throughout; in_valid_i pulses ignored.
REQ-033 DIVU 100/7 -> 14, REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-034 Result backpressure: out_ready_i held low 5 cycles -> out_valid_o and res_o stable for all 5, handoff on the first edge with out_ready_i high.
REQ-035 Reset asserted at EXEC iteration 10 of a DIVU -> outputs at reset values immediately; after release, a new ADD 2+3 returns 5 with latency 1.
